gticc_rx_linkmon: RTL and testbench

GTICC_RX_LINKMON -- requirements
Module: gticc_rx_linkmon

---
 rtl/gticc_rx_linkmon.sv | 173 +++++++++++++++++
 tb/tb_gticc_rx_linkmon.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gticc_rx_linkmon.sv
// Per-lane GT receive link monitor: CDR lock debounce, comma alignment FSM,
// windowed code-error realignment and payload forwarding.
module gticc_rx_linkmon #(
    parameter int          NLANE    = 1,
    parameter int          DWIDTH   = 16,
    parameter int          LOCKMAX  = 3,
    parameter int          ALIGNCNT = 8,
    parameter int          ERRMAX   = 4,
    parameter int          WINDOW   = 1024,
    parameter logic [7:0]  COMMA    = 8'hBC,
    localparam int         DBYTE    = DWIDTH / 8
) (
    input  logic                      RXUSRCLK,
    input  logic                      reset,
    input  logic [NLANE-1:0]          rxcdrlock,
    input  logic [NLANE-1:0]          rxresetdone,
    input  logic [NLANE*DWIDTH-1:0]   rxdata,
    input  logic [NLANE*DBYTE-1:0]    rxcharisk,
    input  logic [NLANE*DBYTE-1:0]    rxdisperr,
    input  logic [NLANE*DBYTE-1:0]    rxnotintable,
    output logic [NLANE-1:0]          locked,
    output logic [NLANE-1:0]          linkup,
    output logic                      all_linkup,
    output logic [NLANE*DWIDTH-1:0]   dout,
    output logic [NLANE-1:0]          dout_valid,
    output logic [NLANE-1:0]          realign_req,
    output logic [NLANE*16-1:0]       errcnt
);

    localparam int LW = $clog2(LOCKMAX + 1);
    localparam int GW = $clog2(ALIGNCNT + 1);
    localparam int EW = $clog2(ERRMAX + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_HUNT = 2'd1,
        ST_SYNC = 2'd2,
        ST_UP   = 2'd3
    } state_t;

    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
        logic [DWIDTH-1:0] data_w;
        logic [DBYTE-1:0]  k_w;
        logic [DBYTE-1:0]  de_w;
        logic [DBYTE-1:0]  nt_w;
        logic              err_w;
        logic              comma_w;
        logic              wrap_w;
        logic [EW-1:0]     errwin_d;

        state_t            state_q;
        logic              locked_q;
        logic              linkup_q;
        logic              dval_q;
        logic              realign_q;
        logic [DWIDTH-1:0] dout_q;
        logic [15:0]       errcnt_q;
        logic [LW-1:0]     unlock_q;
        logic [GW-1:0]     goodcnt_q;
        logic [WW-1:0]     wincnt_q;
        logic [EW-1:0]     errwin_q;

        assign data_w  = rxdata[gi*DWIDTH +: DWIDTH];
        assign k_w     = rxcharisk[gi*DBYTE +: DBYTE];
        assign de_w    = rxdisperr[gi*DBYTE +: DBYTE];
        assign nt_w    = rxnotintable[gi*DBYTE +: DBYTE];

        assign err_w   = |(de_w | nt_w);
        assign comma_w = k_w[0] && (data_w[7:0] == COMMA) && ((k_w >> 1) == '0) && !err_w;

        // An error on the wrap cycle opens the new window rather than closing the old one.
        assign wrap_w   = (wincnt_q == WW'(WINDOW - 1));
        assign errwin_d = (wrap_w ? '0 : errwin_q) + EW'(err_w);

        always_ff @(posedge RXUSRCLK or posedge reset) begin
            if (reset) begin
                state_q   <= ST_DOWN;
                locked_q  <= 1'b0;
                linkup_q  <= 1'b0;
                dval_q    <= 1'b0;
                realign_q <= 1'b0;
                dout_q    <= '0;
                errcnt_q  <= '0;
                unlock_q  <= '0;
                goodcnt_q <= '0;
                wincnt_q  <= '0;
                errwin_q  <= '0;
            end else begin
                if (rxcdrlock[gi]) begin
                    locked_q <= 1'b1;
                    unlock_q <= '0;
                end else begin
                    if (unlock_q != LW'(LOCKMAX))
                        unlock_q <= unlock_q + 1'b1;
                    if (unlock_q >= LW'(LOCKMAX - 1))
                        locked_q <= 1'b0;
                end

                if (err_w && (state_q != ST_DOWN) && (errcnt_q != 16'hFFFF))
                    errcnt_q <= errcnt_q + 1'b1;

                realign_q <= 1'b0;
                dout_q    <= '0;
                dval_q    <= 1'b0;
                linkup_q  <= 1'b0;

                if (!locked_q || !rxresetdone[gi]) begin
                    state_q   <= ST_DOWN;
                    goodcnt_q <= '0;
                end else begin
                    case (state_q)
                        ST_DOWN: begin
                            state_q   <= ST_HUNT;
                            goodcnt_q <= '0;
                        end
                        ST_HUNT: begin
                            if (comma_w) begin
                                goodcnt_q <= GW'(1);
                                if (ALIGNCNT <= 1) begin
                                    state_q  <= ST_UP;
                                    linkup_q <= 1'b1;
                                    wincnt_q <= '0;
                                    errwin_q <= '0;
                                end else begin
                                    state_q <= ST_SYNC;
                                end
                            end
                        end
                        ST_SYNC: begin
                            if (err_w) begin
                                state_q   <= ST_HUNT;
                                goodcnt_q <= '0;
                            end else if (comma_w) begin
                                goodcnt_q <= goodcnt_q + 1'b1;
                                if (goodcnt_q == GW'(ALIGNCNT - 1)) begin
                                    state_q  <= ST_UP;
                                    linkup_q <= 1'b1;
                                    wincnt_q <= '0;
                                    errwin_q <= '0;
                                end
                            end
                        end
                        ST_UP: begin
                            if (errwin_d >= EW'(ERRMAX)) begin
                                state_q   <= ST_HUNT;
                                goodcnt_q <= '0;
                                realign_q <= 1'b1;
                            end else begin
                                linkup_q <= 1'b1;
                                dout_q   <= data_w;
                                dval_q   <= !comma_w;
                                wincnt_q <= wrap_w ? '0 : wincnt_q + 1'b1;
                                errwin_q <= errwin_d;
                            end
                        end
                        default: state_q <= ST_DOWN;
                    endcase
                end
            end
        end

        assign locked[gi]                = locked_q;
        assign linkup[gi]                = linkup_q;
        assign dout[gi*DWIDTH +: DWIDTH] = dout_q;
        assign dout_valid[gi]            = dval_q;
        assign realign_req[gi]           = realign_q;
        assign errcnt[gi*16 +: 16]       = errcnt_q;
    end

    assign all_linkup = &linkup;

endmodule

// File: tb/tb_gticc_rx_linkmon.sv
// Directed bench for gticc_rx_linkmon: two lanes, short error window so
// window wrap and realignment can be exercised in a few dozen cycles.
module tb_gticc_rx_linkmon;

    localparam int NLANE  = 2;
    localparam int DWIDTH = 16;
    localparam int DBYTE  = 2;

    logic                    clk;
    logic                    reset;
    logic [NLANE-1:0]        rxcdrlock;
    logic [NLANE-1:0]        rxresetdone;
    logic [NLANE*DWIDTH-1:0] rxdata;
    logic [NLANE*DBYTE-1:0]  rxcharisk;
    logic [NLANE*DBYTE-1:0]  rxdisperr;
    logic [NLANE*DBYTE-1:0]  rxnotintable;
    logic [NLANE-1:0]        locked;
    logic [NLANE-1:0]        linkup;
    logic                    all_linkup;
    logic [NLANE*DWIDTH-1:0] dout;
    logic [NLANE-1:0]        dout_valid;
    logic [NLANE-1:0]        realign_req;
    logic [NLANE*16-1:0]     errcnt;

    int checks   = 0;
    int failures = 0;

    gticc_rx_linkmon #(
        .NLANE   (NLANE),
        .DWIDTH  (DWIDTH),
        .LOCKMAX (3),
        .ALIGNCNT(8),
        .ERRMAX  (4),
        .WINDOW  (16),
        .COMMA   (8'hBC)
    ) dut (
        .RXUSRCLK    (clk),
        .reset       (reset),
        .rxcdrlock   (rxcdrlock),
        .rxresetdone (rxresetdone),
        .rxdata      (rxdata),
        .rxcharisk   (rxcharisk),
        .rxdisperr   (rxdisperr),
        .rxnotintable(rxnotintable),
        .locked      (locked),
        .linkup      (linkup),
        .all_linkup  (all_linkup),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .realign_req (realign_req),
        .errcnt      (errcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        if (obs === exp) $display("check %s ok value=%h", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int ln, input logic [15:0] d, input logic [1:0] k,
                            input logic [1:0] de);
        rxdata[ln*16 +: 16]   = d;
        rxcharisk[ln*2 +: 2]  = k;
        rxdisperr[ln*2 +: 2]  = de;
        rxnotintable[ln*2 +: 2] = 2'b00;
    endtask

    task automatic comma(input int ln);
        set_lane(ln, 16'h00BC, 2'b01, 2'b00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"},  32'(locked),      0);
        chk({tag, "_linkup"},  32'(linkup),      0);
        chk({tag, "_all"},     32'(all_linkup),  0);
        chk({tag, "_dout"},    32'(dout),        0);
        chk({tag, "_dvalid"},  32'(dout_valid),  0);
        chk({tag, "_realign"}, 32'(realign_req), 0);
        chk({tag, "_errcnt"},  32'(errcnt),      0);
    endtask

    initial begin
        reset        = 1'b1;
        rxcdrlock    = '0;
        rxresetdone  = '0;
        rxdata       = '0;
        rxcharisk    = '0;
        rxdisperr    = '0;
        rxnotintable = '0;

        // Reset state
        #2;
        chk_all_zero("rst");
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_locked", 32'(locked), 0);

        // Both lanes lock and align on 8 commas
        comma(0);
        comma(1);
        rxcdrlock   = 2'b11;
        rxresetdone = 2'b11;
        tick();
        chk("lock_up", 32'(locked), 'h3);
        chk("lock_up_linkup", 32'(linkup), 0);
        tick();
        repeat (7) tick();
        chk("seven_commas_linkup", 32'(linkup), 0);
        tick();
        chk("eight_commas_linkup", 32'(linkup), 'h3);
        chk("eight_commas_all", 32'(all_linkup), 1);
        chk("entry_dvalid", 32'(dout_valid), 0);

        // Payload forwarding
        set_lane(0, 16'h1234, 2'b00, 2'b00);
        tick();
        chk("data_dout", 32'(dout[15:0]), 'h1234);
        chk("data_dvalid", 32'(dout_valid), 'h1);
        comma(0);
        tick();
        chk("comma_dvalid", 32'(dout_valid), 0);
        chk("comma_dout", 32'(dout[15:0]), 'h00BC);

        // Lock debounce: 2 lows tolerated, 3 lows drop the lane
        set_lane(0, 16'h5555, 2'b00, 2'b00);
        rxcdrlock[0] = 1'b0;
        tick();
        tick();
        chk("two_low_locked", 32'(locked), 'h3);
        chk("two_low_dvalid", 32'(dout_valid[0]), 1);
        rxcdrlock[0] = 1'b1;
        tick();
        chk("relock_linkup", 32'(linkup), 'h3);
        rxcdrlock[0] = 1'b0;
        tick();
        tick();
        chk("low2_locked", 32'(locked), 'h3);
        tick();
        chk("low3_locked", 32'(locked), 'h2);
        chk("low3_linkup", 32'(linkup), 'h3);
        tick();
        chk("down_linkup", 32'(linkup), 'h2);
        chk("down_dvalid", 32'(dout_valid), 0);
        chk("down_realign", 32'(realign_req), 0);
        chk("down_all", 32'(all_linkup), 0);

        // SYNC interrupted by a disparity error, then realign
        comma(0);
        rxcdrlock[0] = 1'b1;
        tick();
        tick();
        repeat (5) tick();
        set_lane(0, 16'h00BC, 2'b01, 2'b01);
        tick();
        chk("sync_err_errcnt", 32'(errcnt[15:0]), 1);
        chk("sync_err_linkup", 32'(linkup), 'h2);
        comma(0);
        repeat (7) tick();
        chk("resync7_linkup", 32'(linkup), 'h2);
        tick();
        chk("resync8_linkup", 32'(linkup), 'h3);
        chk("resync8_all", 32'(all_linkup), 1);

        // Error window: windows are edges [1..15], [16..31], [32..47] after entry
        for (int k = 1; k <= 36; k++) begin
            if ((k >= 13 && k <= 18) || (k >= 32 && k <= 35))
                set_lane(0, 16'h0000, 2'b00, 2'b01);
            else
                comma(0);
            tick();
            if (k == 16) begin
                chk("wrap_err_linkup", 32'(linkup), 'h3);
                chk("wrap_err_realign", 32'(realign_req), 0);
            end
            if (k == 18) begin
                chk("win_3_3_linkup", 32'(linkup), 'h3);
                chk("win_3_3_errcnt", 32'(errcnt[15:0]), 7);
            end
            if (k == 34) chk("err3_realign", 32'(realign_req), 0);
            if (k == 35) begin
                chk("err4_realign", 32'(realign_req), 'h1);
                chk("err4_linkup", 32'(linkup), 'h2);
                chk("err4_errcnt", 32'(errcnt[15:0]), 11);
                chk("err4_dvalid", 32'(dout_valid[0]), 0);
            end
            if (k == 36) chk("realign_pulse_end", 32'(realign_req), 0);
        end

        // Error counter saturation, then asynchronous reset
        set_lane(0, 16'h0000, 2'b00, 2'b01);
        repeat (100) tick();
        chk("errcnt_100", 32'(errcnt[15:0]), 111);
        repeat (70000) @(posedge clk);
        #1;
        chk("errcnt_sat", 32'(errcnt[15:0]), 'hFFFF);
        chk("errcnt_lane1", 32'(errcnt[31:16]), 0);
        chk("lane1_still_up", 32'(linkup[1]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        reset = 1'b0;
        comma(0);
        tick();
        chk("after_rst_locked", 32'(locked), 'h3);
        chk("after_rst_linkup", 32'(linkup), 0);
        chk("after_rst_realign", 32'(realign_req), 0);
        chk("after_rst_errcnt", 32'(errcnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
